vm1_bus_sequencer: RTL
======================

# vm1_bus_sequencer

Bus-cycle sequencer and DMA arbiter for the VM1 datapath, clocked on `clkdbi`. It turns single-cycle CPU transfer requests (address on `dba`, data on `dbo`) into asynchronous-bus SYNC/DIN/DOUT/RPLY handshakes. It generates the `cedbi`/`din_active` pair that captures read data into the datapath. It grants the bus to one external DMA master between CPU cycles, and reports completion or bus-timeout to the microcode controller.

## Interface
- `TIMEOUT`, 64: `clkdbi` cycles to wait for RPLY before aborting with bus error; legal range 4..255.
- `clkdbi` in 1: block clock; all state changes on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_rd` in 1: CPU read request, held until `done` or `buserr`.
- `req_wr` in 1: CPU write request, held until `done` or `buserr`.
- `req_rmw` in 1: qualifies `req_rd`; keeps SYNC asserted after the read for a following write.
- `req_byte` in 1: byte write; drives `bus_wtbt` during the DOUT phase.
- `dba` in 16: transfer address; sampled in IDLE on request acceptance.
- `dbo` in 16: write data; sampled when DOUT phase starts.
- `bus_ad_out` out 16: multiplexed address/data out.
- `bus_ad_oe` out 1: output enable for `bus_ad_out`.
- `bus_sync` out 1: address strobe.
- `bus_din` out 1: read strobe.
- `bus_dout` out 1: write strobe.
- `bus_wtbt` out 1: write/byte qualifier.
- `bus_rply` in 1: slave reply, pre-synchronised externally.
- `bus_dmr` in 1: DMA request.
- `bus_dmgo` out 1: DMA grant.
- `bus_sack` in 1: DMA master acknowledge, held while it owns the bus.
- `cedbi` out 1: one-cycle capture strobe for the datapath `dbi_reg`.
- `din_active` out 1: datapath selects live `dbi`.
- `done` out 1: one-cycle pulse when the CPU transfer completes.
- `buserr` out 1: one-cycle pulse on timeout or DMA-grant abandonment.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, ADDR, DIN, DOUT, RMW_HOLD, END, DMA_GNT, DMA_OWN.
- IDLE arbitration:
  - `bus_dmr` has priority over CPU requests → DMA_GNT.
  - Otherwise `req_rd` or `req_wr` → ADDR, latching `dba` and the request type. `req_rd` wins if both are set.
- ADDR:
  - `bus_ad_out`=address, `bus_ad_oe`=1, `bus_sync`=1.
  - `bus_wtbt`=1 if the request is a write.
  - Next cycle → DIN (read) or DOUT (write).
- DIN:
  - `bus_din`=1, `din_active`=1, `bus_ad_oe`=0, SYNC held.
  - On `bus_rply`: `cedbi`=1 that same cycle.
  - Then → END, or → RMW_HOLD if `req_rmw` is set (`done` pulses in both cases).
- RMW_HOLD: SYNC held, no strobes. On `req_wr` → DOUT; a write issued here skips ADDR.
- DOUT:
  - `bus_ad_out`=`dbo` latched on entry, `bus_ad_oe`=1, `bus_dout`=1.
  - `bus_wtbt`=`req_byte`.
  - On `bus_rply` → END.
- END:
  - All strobes 0; `done` pulses on entry for writes.
  - Remains until `bus_rply`=0, then → IDLE. END is also subject to the timeout.
- Timeout:
  - Counter clears on entry to DIN, DOUT, END or DMA_GNT.
  - Counter reaching `TIMEOUT` in DIN, DOUT or END → `buserr` pulse, all strobes dropped, → IDLE.
  - A timeout in END pulses `buserr` only if `done` has not already pulsed for that transfer.
- DMA:
  - DMA_GNT: `bus_dmgo`=1 until `bus_sack` → DMA_OWN (`dmgo` drops).
  - DMA_GNT times out → IDLE, with no `buserr` (the master vanished).
  - DMA_OWN: all block outputs inactive, `bus_ad_oe`=0. Leave on `bus_sack`=0 → IDLE.
  - DMA_OWN has no timeout.
- A CPU request that arrives while DMA is active waits in IDLE. The request stays held, so nothing is lost.

## Timing
- Reset (asynchronous, immediate):
  - State=IDLE; every output 0, including `bus_ad_out`=0.
  - Counter=0 and latches cleared.
  - A cycle interrupted mid-transfer is abandoned without `done` or `buserr`.
- Read latency: request seen in IDLE at cycle 0; ADDR at cycle 1; DIN from cycle 2.
  - With RPLY seen at cycle k ≥ 2, `cedbi` and `done` assert at cycle k.
  - END follows at k+1.
- `din_active` falls the cycle after `cedbi`. The datapath then uses `dbi_reg`, which holds the captured word.
- `done` and `buserr` are mutually exclusive in any cycle, and each is exactly one cycle wide.
- RPLY already high on DIN/DOUT entry is accepted in the first cycle.
- A new request is accepted no earlier than the cycle after END exits.
- The counter is 8 bits and saturates; it does not wrap.

## Structure
- Shared package `vm1_bus_pkg`: state encoding constants and the `TIMEOUT` default.
- One sub-module, `vm1_bus_timer`: the saturating counter with clear and `expired` output, reused by a future interrupt-acknowledge sequencer.

## Test plan
- Read at 0o177660, RPLY at cycle 5 with data 0o123456 → SYNC from cycle 1, DIN cycles 2–5, `cedbi`/`done` at 5, captured 0o123456, IDLE after RPLY drops.
- Byte write of 0o000377 to 0o001000 → ADDR shows 0o001000, DOUT shows 0o000377 with `wtbt`=1, `done` at the END entry.
- RMW: read then `req_wr` 3 cycles later → SYNC continuous, no second ADDR, two `done` pulses.
- No RPLY with `TIMEOUT`=8 → `buserr` at cycle 10 (entry at 2, plus 8), strobes low, `done` never asserted.
- `bus_dmr` and `req_rd` in the same cycle → `dmgo` first; `sack` held 20 cycles; CPU read starts the cycle after IDLE is re-entered.
- `reset_n` low during DOUT → outputs 0 immediately, IDLE, no pulses on release.

Source files
------------

// File: rtl/vm1_bus_pkg.sv
// Shared definitions for the VM1 bus-cycle sequencer: state encoding, widths, timeout default.
package vm1_bus_pkg;

  localparam int unsigned AD_W            = 16;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_DIN      = 3'd2,
    S_DOUT     = 3'd3,
    S_RMW_HOLD = 3'd4,
    S_END      = 3'd5,
    S_DMA_GNT  = 3'd6,
    S_DMA_OWN  = 3'd7
  } state_t;

  // Registered bus-side outputs of the sequencer
  typedef struct packed {
    logic [AD_W-1:0] ad;
    logic            ad_oe;
    logic            sync;
    logic            din;
    logic            dout;
    logic            wtbt;
    logic            dmgo;
  } bus_out_t;

endpackage

// File: rtl/vm1_bus_sequencer_if.sv
// Asynchronous VM1 bus: multiplexed AD lines, strobes, reply and DMA handshake.
interface vm1_bus_sequencer_if;
  import vm1_bus_pkg::*;

  logic [AD_W-1:0] bus_ad_out;
  logic            bus_ad_oe;
  logic            bus_sync;
  logic            bus_din;
  logic            bus_dout;
  logic            bus_wtbt;
  logic            bus_rply;
  logic            bus_dmr;
  logic            bus_dmgo;
  logic            bus_sack;

  modport master (
    output bus_ad_out, bus_ad_oe, bus_sync, bus_din, bus_dout, bus_wtbt, bus_dmgo,
    input  bus_rply, bus_dmr, bus_sack
  );

  modport slave (
    input  bus_ad_out, bus_ad_oe, bus_sync, bus_din, bus_dout, bus_wtbt, bus_dmgo,
    output bus_rply, bus_dmr, bus_sack
  );
endinterface

// File: rtl/vm1_bus_timer.sv
// Saturating cycle counter with synchronous clear; flags when the limit has been reached.
module vm1_bus_timer
  import vm1_bus_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clkdbi,
  input  logic reset_n,
  input  logic clear,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clkdbi or negedge reset_n) begin
    if (!reset_n)            count <= '0;
    else if (clear)          count <= '0;
    else if (count != '1)    count <= count + CNT_W'(1);
  end

  assign expired = (count >= CNT_W'(LIMIT));

endmodule

// File: rtl/vm1_bus_sequencer.sv
// Bus-cycle sequencer and single-master DMA arbiter: CPU requests to SYNC/DIN/DOUT/RPLY cycles.
module vm1_bus_sequencer
  import vm1_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clkdbi,
  input  logic             reset_n,
  input  logic             req_rd,
  input  logic             req_wr,
  input  logic             req_rmw,
  input  logic             req_byte,
  input  logic [AD_W-1:0]  dba,
  input  logic [AD_W-1:0]  dbo,
  vm1_bus_sequencer_if.master bus,
  output logic             cedbi,
  output logic             din_active,
  output logic             done,
  output logic             buserr,
  output logic             busy
);

  state_t          state, state_d;
  bus_out_t        out_q, out_d;
  logic            is_wr, is_wr_d;
  logic            done_wr, done_wr_d;
  logic            done_seen, done_seen_d;
  logic            done_rd;
  logic [AD_W-1:0] ad_d;
  logic            wtbt_d;
  logic            tmr_clear;
  logic            expired;

  vm1_bus_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clkdbi  (clkdbi),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .expired (expired)
  );

  always_ff @(posedge clkdbi or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      out_q      <= '0;
      is_wr      <= 1'b0;
      done_wr    <= 1'b0;
      done_seen  <= 1'b0;
      din_active <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      out_q      <= out_d;
      is_wr      <= is_wr_d;
      done_wr    <= done_wr_d;
      done_seen  <= done_seen_d;
      din_active <= (state_d == S_DIN);
      busy       <= (state_d != S_IDLE);
    end
  end

  // Reply-driven strobes (cedbi, read done, buserr) are Mealy so capture lands in the RPLY cycle
  always_comb begin
    state_d   = state;
    is_wr_d   = is_wr;
    done_wr_d = 1'b0;
    done_rd   = 1'b0;
    cedbi     = 1'b0;
    buserr    = 1'b0;
    ad_d      = '0;
    wtbt_d    = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.bus_dmr) begin
          state_d = S_DMA_GNT;
        end else if (req_rd || req_wr) begin
          state_d = S_ADDR;
          is_wr_d = !req_rd;
          ad_d    = dba;
          wtbt_d  = !req_rd;
        end
      end
      S_ADDR: begin
        if (is_wr) begin
          state_d = S_DOUT;
          ad_d    = dbo;
          wtbt_d  = req_byte;
        end else begin
          state_d = S_DIN;
        end
      end
      S_DIN: begin
        if (bus.bus_rply) begin
          cedbi   = 1'b1;
          done_rd = 1'b1;
          state_d = req_rmw ? S_RMW_HOLD : S_END;
        end else if (expired) begin
          buserr  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RMW_HOLD: begin
        if (req_wr) begin
          state_d = S_DOUT;
          is_wr_d = 1'b1;
          ad_d    = dbo;
          wtbt_d  = req_byte;
        end
      end
      S_DOUT: begin
        ad_d   = out_q.ad;
        wtbt_d = out_q.wtbt;
        if (bus.bus_rply) begin
          state_d   = S_END;
          done_wr_d = 1'b1;
          ad_d      = '0;
          wtbt_d    = 1'b0;
        end else if (expired) begin
          buserr  = 1'b1;
          state_d = S_IDLE;
          ad_d    = '0;
          wtbt_d  = 1'b0;
        end
      end
      S_END: begin
        if (!bus.bus_rply) begin
          state_d = S_IDLE;
        end else if (expired) begin
          buserr  = !(done_seen || done_wr);
          state_d = S_IDLE;
        end
      end
      S_DMA_GNT: begin
        if (bus.bus_sack)  state_d = S_DMA_OWN;
        else if (expired)  state_d = S_IDLE;
      end
      S_DMA_OWN: begin
        if (!bus.bus_sack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done = done_rd || done_wr;

    // Each data phase (ADDR start or DOUT entry) begins with no completion reported yet
    if (state_d == S_ADDR || (state_d == S_DOUT && state != S_DOUT))
      done_seen_d = 1'b0;
    else
      done_seen_d = done_seen || done;

    tmr_clear = (state_d != state) &&
                (state_d inside {S_DIN, S_DOUT, S_END, S_DMA_GNT});

    out_d.ad    = ad_d;
    out_d.ad_oe = (state_d inside {S_ADDR, S_DOUT});
    out_d.sync  = (state_d inside {S_ADDR, S_DIN, S_RMW_HOLD, S_DOUT});
    out_d.din   = (state_d == S_DIN);
    out_d.dout  = (state_d == S_DOUT);
    out_d.wtbt  = wtbt_d;
    out_d.dmgo  = (state_d == S_DMA_GNT);
  end

  assign bus.bus_ad_out = out_q.ad;
  assign bus.bus_ad_oe  = out_q.ad_oe;
  assign bus.bus_sync   = out_q.sync;
  assign bus.bus_din    = out_q.din;
  assign bus.bus_dout   = out_q.dout;
  assign bus.bus_wtbt   = out_q.wtbt;
  assign bus.bus_dmgo   = out_q.dmgo;

endmodule
